matrix_alloc: RTL
=================

MATRIX_ALLOC -- requirements
Module: matrix_alloc

Interface
REQ-001 Parameters: SLOTS=16, number of matrix slots; SLOT_WORDS=25, words per slot; PER_DIM=2, max stored matrices per (m,n) class.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 en_input  in  1  input session active; low = abort.
REQ-005 dims_valid  in  1  level, dims on dim_m/dim_n requested for allocation.
REQ-006 dim_m, dim_n  in  32 each  matrix dimensions; legal range 1..5.
REQ-007 in_we / in_addr / in_data  in  1/9/32  element write from input stage; in_addr is absolute.
REQ-008 rx_done  in  1  pulse, matrix input complete.
REQ-009 q_req / q_m / q_n / q_idx  in  1/3/3/2  lookup request; q_idx 1=oldest, 2=newest of class.
REQ-010 base_addr  out  9  granted slot base = slot*SLOT_WORDS.
REQ-011 addr_ready  out  1  one-cycle grant pulse.
REQ-012 mem_we / mem_addr / mem_data  out  1/9/4  registered write port to matrix RAM; data = in_data[3:0].
REQ-013 alloc_err  out  1  one-cycle pulse: illegal dims, no slot, or out-of-range write.
REQ-014 q_hit / q_base  out  1/9  lookup result, valid one cycle after q_req.

Function
REQ-015 Slot table per slot: valid, m[2:0], n[2:0], newest bit.
REQ-016 States: IDLE, SEARCH, DECIDE, GRANT, FILL.
REQ-017 IDLE: dims_valid&en_input with dims legal -> SEARCH, scan index 0; illegal dims -> alloc_err pulse, stay IDLE until dims_valid drops.
REQ-018 SEARCH scans one slot per cycle (16 cycles): records lowest free slot, count of valid slots matching class, index of matching slot with newest=0.
REQ-019 DECIDE: class count==PER_DIM -> victim = older class slot; else lowest free slot; none free -> alloc_err, IDLE.
REQ-020 GRANT: base_addr <= victim*25, addr_ready=1 exactly one cycle, -> FILL; addr_ready rises 18 cycles after dims_valid sampled in IDLE.
REQ-021 FILL: in_we with base_addr<=in_addr<=base_addr+24 -> mem_we=1 next cycle with same addr/data; otherwise no mem_we, alloc_err pulse.
REQ-022 FILL, rx_done: slot valid=1, dims stored, newest=1, other same-class slot newest=0; -> IDLE.
REQ-023 en_input low in SEARCH/DECIDE/GRANT/FILL -> IDLE next cycle, table unchanged; victim slot contents stay marked as before (overwritten words not restored).
REQ-024 rx_done and en_input low in same cycle: commit takes priority.
REQ-025 in_we outside FILL ignored silently.
REQ-026 Lookup: registered, every state; q_idx=1 hits oldest (or sole) match, q_idx=2 hits newest only if two present; miss -> q_hit=0, q_base=0; query coincident with commit sees pre-commit table.
REQ-027 Width: base math 4-bit slot * 25 into 9 bits, max 375; dims compared on low 3 bits after range check on full 32.

Reset
REQ-028 rst_n low at clock edge: state IDLE, all slots invalid, newest=0, base_addr=0, addr_ready=0, mem_we=0, mem_addr=0, mem_data=0, alloc_err=0, q_hit=0, q_base=0.
REQ-029 Reset mid-FILL discards allocation; no mem_we in cycle following reset.

Structure
REQ-030 Shared package: SLOTS, SLOT_WORDS, PER_DIM, DIM_MAX=5, state encoding, slot record type.
REQ-031 One sub-module slot_table (storage, commit, lookup); FSM and write guard in top.

Verification
REQ-032 Reset, dims 2x3 -> addr_ready at +18 cycles, base_addr=0; 6 writes 0..5 -> mem_we x6; rx_done -> lookup (2,3,1) q_hit=1, q_base=0.
REQ-033 Three 2x3 commits -> third reuses slot 0, base 0; lookup idx1 -> base 25, idx2 -> base 0.
REQ-034 dims 6x2 -> alloc_err pulse, no addr_ready; 16 distinct-class commits then new class -> alloc_err.
REQ-035 FILL with base 25, in_addr=50 -> no mem_we, alloc_err pulse.
REQ-036 en_input dropped at SEARCH cycle 5 -> IDLE, no addr_ready, table unchanged.
REQ-037 rst_n low during FILL -> all outputs 0, lookup (2,3,1) misses.

Source files
------------

// File: rtl/matrix_alloc_pkg.sv
// Shared constants, FSM state encoding and slot record for the matrix allocator.
package matrix_alloc_pkg;

  localparam int SLOTS      = 16;
  localparam int SLOT_WORDS = 25;
  localparam int PER_DIM    = 2;
  localparam int DIM_MAX    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_DECIDE,
    S_GRANT,
    S_FILL
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] m;
    logic [2:0] n;
    logic       newest;
  } slot_t;

  // Base word address of a slot in the matrix RAM (max 15*25 = 375).
  function automatic logic [8:0] slot_base(input logic [3:0] slot);
    return {5'b0, slot} * 9'(SLOT_WORDS);
  endfunction

endpackage

// File: rtl/matrix_alloc_slot_table.sv
// Slot table: per-slot class record, commit update, scan read port and
// registered (m,n,idx) lookup.
module slot_table
  import matrix_alloc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rd_idx,
  output slot_t      rd_entry,
  input  logic       commit,
  input  logic [3:0] commit_idx,
  input  logic [2:0] commit_m,
  input  logic [2:0] commit_n,
  input  logic       q_req,
  input  logic [2:0] q_m,
  input  logic [2:0] q_n,
  input  logic [1:0] q_idx,
  output logic       q_hit,
  output logic [8:0] q_base
);

  slot_t      table_q [SLOTS];
  slot_t      table_d [SLOTS];
  logic       q_hit_q, q_hit_d;
  logic [8:0] q_base_q, q_base_d;

  assign rd_entry = table_q[rd_idx];
  assign q_hit    = q_hit_q;
  assign q_base   = q_base_q;

  // Commit: install the new record as newest and demote its class sibling.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      table_d[i] = table_q[i];
      if (commit && table_q[i].valid && table_q[i].m == commit_m &&
          table_q[i].n == commit_n && 4'(i) != commit_idx)
        table_d[i].newest = 1'b0;
    end
    if (commit) begin
      table_d[commit_idx].valid  = 1'b1;
      table_d[commit_idx].m      = commit_m;
      table_d[commit_idx].n      = commit_n;
      table_d[commit_idx].newest = 1'b1;
    end
  end

  // Lookup against the current (pre-commit) table contents.
  always_comb begin
    logic [4:0] cnt;
    logic [3:0] any_idx, old_idx, new_idx;
    cnt     = '0;
    any_idx = '0;
    old_idx = '0;
    new_idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (table_q[i].valid && table_q[i].m == q_m && table_q[i].n == q_n) begin
        if (cnt == 5'd0) any_idx = 4'(i);
        cnt = cnt + 5'd1;
        if (table_q[i].newest) new_idx = 4'(i);
        else                   old_idx = 4'(i);
      end
    end
    q_hit_d  = 1'b0;
    q_base_d = '0;
    if (q_req) begin
      if (q_idx == 2'd1 && cnt == 5'd1) begin
        q_hit_d  = 1'b1;
        q_base_d = slot_base(any_idx);
      end else if (q_idx == 2'd1 && cnt >= 5'(PER_DIM)) begin
        q_hit_d  = 1'b1;
        q_base_d = slot_base(old_idx);
      end else if (q_idx == 2'd2 && cnt >= 5'(PER_DIM)) begin
        q_hit_d  = 1'b1;
        q_base_d = slot_base(new_idx);
      end
    end
  end

  // Table and lookup registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) table_q[i] <= '0;
      q_hit_q  <= 1'b0;
      q_base_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) table_q[i] <= table_d[i];
      q_hit_q  <= q_hit_d;
      q_base_q <= q_base_d;
    end
  end

endmodule

// File: rtl/matrix_alloc.sv
// Matrix slot allocator: 16-cycle table scan, victim choice, grant, guarded
// element write-through to the matrix RAM and commit on rx_done.
module matrix_alloc
  import matrix_alloc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_input,
  input  logic        dims_valid,
  input  logic [31:0] dim_m,
  input  logic [31:0] dim_n,
  input  logic        in_we,
  input  logic [8:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        rx_done,
  input  logic        q_req,
  input  logic [2:0]  q_m,
  input  logic [2:0]  q_n,
  input  logic [1:0]  q_idx,
  output logic [8:0]  base_addr,
  output logic        addr_ready,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [3:0]  mem_data,
  output logic        alloc_err,
  output logic        q_hit,
  output logic [8:0]  q_base
);

  state_t     state_q, state_d;
  logic [3:0] scan_q, scan_d;
  logic       free_found_q, free_found_d;
  logic [3:0] free_idx_q, free_idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] old_idx_q, old_idx_d;
  logic [3:0] victim_q, victim_d;
  logic [2:0] cls_m_q, cls_m_d;
  logic [2:0] cls_n_q, cls_n_d;
  logic       err_hold_q, err_hold_d;
  logic [8:0] base_addr_q, base_addr_d;
  logic       addr_ready_q, addr_ready_d;
  logic       mem_we_q, mem_we_d;
  logic [8:0] mem_addr_q, mem_addr_d;
  logic [3:0] mem_data_q, mem_data_d;
  logic       alloc_err_q, alloc_err_d;
  logic       commit;
  slot_t      rd_entry;
  logic       dims_legal;
  logic       in_range;
  logic       unused_data_hi;

  assign unused_data_hi = ^in_data[31:4];

  assign dims_legal = (dim_m >= 32'd1) && (dim_m <= 32'(DIM_MAX)) &&
                      (dim_n >= 32'd1) && (dim_n <= 32'(DIM_MAX));
  assign in_range   = (in_addr >= base_addr_q) &&
                      ({1'b0, in_addr} <= ({1'b0, base_addr_q} + 10'd24));

  assign base_addr  = base_addr_q;
  assign addr_ready = addr_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign alloc_err  = alloc_err_q;

  slot_table u_slot_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (scan_q),
    .rd_entry   (rd_entry),
    .commit     (commit),
    .commit_idx (victim_q),
    .commit_m   (cls_m_q),
    .commit_n   (cls_n_q),
    .q_req      (q_req),
    .q_m        (q_m),
    .q_n        (q_n),
    .q_idx      (q_idx),
    .q_hit      (q_hit),
    .q_base     (q_base)
  );

  // Next-state, scan bookkeeping and registered output values.
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    cnt_d        = cnt_q;
    old_idx_d    = old_idx_q;
    victim_d     = victim_q;
    cls_m_d      = cls_m_q;
    cls_n_d      = cls_n_q;
    err_hold_d   = err_hold_q;
    base_addr_d  = base_addr_q;
    addr_ready_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    alloc_err_d  = 1'b0;
    commit       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_hold_q) begin
          if (!dims_valid) err_hold_d = 1'b0;
        end else if (dims_valid && en_input) begin
          if (dims_legal) begin
            state_d      = S_SEARCH;
            scan_d       = '0;
            free_found_d = 1'b0;
            free_idx_d   = '0;
            cnt_d        = '0;
            old_idx_d    = '0;
            cls_m_d      = dim_m[2:0];
            cls_n_d      = dim_n[2:0];
          end else begin
            alloc_err_d = 1'b1;
            err_hold_d  = 1'b1;
          end
        end
      end
      S_SEARCH: begin
        if (!en_input) begin
          state_d = S_IDLE;
        end else begin
          if (!rd_entry.valid && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = scan_q;
          end
          if (rd_entry.valid && rd_entry.m == cls_m_q && rd_entry.n == cls_n_q) begin
            cnt_d = cnt_q + 5'd1;
            if (!rd_entry.newest) old_idx_d = scan_q;
          end
          if (scan_q == 4'(SLOTS - 1)) state_d = S_DECIDE;
          else                         scan_d  = scan_q + 4'd1;
        end
      end
      S_DECIDE: begin
        if (!en_input) begin
          state_d = S_IDLE;
        end else if (cnt_q >= 5'(PER_DIM)) begin
          victim_d = old_idx_q;
          state_d  = S_GRANT;
        end else if (free_found_q) begin
          victim_d = free_idx_q;
          state_d  = S_GRANT;
        end else begin
          alloc_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!en_input) begin
          state_d = S_IDLE;
        end else begin
          base_addr_d  = slot_base(victim_q);
          addr_ready_d = 1'b1;
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        if (in_we) begin
          if (in_range) begin
            mem_we_d   = 1'b1;
            mem_addr_d = in_addr;
            mem_data_d = in_data[3:0];
          end else begin
            alloc_err_d = 1'b1;
          end
        end
        // Commit wins over a simultaneous abort.
        if (rx_done) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (!en_input) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scan_q       <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      cnt_q        <= '0;
      old_idx_q    <= '0;
      victim_q     <= '0;
      cls_m_q      <= '0;
      cls_n_q      <= '0;
      err_hold_q   <= 1'b0;
      base_addr_q  <= '0;
      addr_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      alloc_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      cnt_q        <= cnt_d;
      old_idx_q    <= old_idx_d;
      victim_q     <= victim_d;
      cls_m_q      <= cls_m_d;
      cls_n_q      <= cls_n_d;
      err_hold_q   <= err_hold_d;
      base_addr_q  <= base_addr_d;
      addr_ready_q <= addr_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      alloc_err_q  <= alloc_err_d;
    end
  end

endmodule
